// File: rtl/dk_sprite_ctrl.sv
// dk_sprite_ctrl: Donkey Kong sprite sequencer and address generator.
//
// Holds DK's screen column and runs the idle / walk-right / walk-left / throw
// state machine once per frame_tick. Chooses the sprite bank, animation phase
// and horizontal mirroring. Converts VGA pixel counters into sprite-local
// addresses and masks the returned colour index into draw_dk.
//
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   frame_tick        one-cycle pulse at the start of vblank
//   enable            level, 1 = walk, 0 = idle
//   throw_req         level request, held until throw_ack
//   throw_ack         one-cycle pulse when a throw is accepted
//   horz, vert        current VGA column / row
//   dk_x              sprite left column
//   spr_horz/vert     sprite-local address to sprite memory
//   spr_sel           0 = front bank, 1 = side bank, 2 = throw bank
//   spr_frame         walk animation phase
//   mirror            horizontal flip applied to spr_horz
//   pix_in            colour index from the selected sprite memory
//   hit               (DK_HIT_FLASH_EN only) starts a blink period
//   draw_dk           masked colour index to the mixer, 0 = transparent
//
// Optional feature macro: DK_HIT_FLASH_EN adds the hit input and a blink
// counter that blanks draw_dk in 4-frame periods after a hit.
//
// Pixel latency: draw_dk for a pixel appears two clocks after it is presented.

module dk_sprite_ctrl #(
    parameter int unsigned SPR_W        = 64,
    parameter int unsigned SPR_H        = 32,
    parameter int unsigned DK_Y         = 40,
    parameter int unsigned X_MIN        = 0,
    parameter int unsigned X_MAX        = 576,
    parameter int unsigned STEP         = 2,
    parameter int unsigned ANIM_DIV     = 8,
    parameter int unsigned THROW_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       throw_req,
    output logic       throw_ack,
    input  logic [9:0] horz,
    input  logic [9:0] vert,
    output logic [9:0] dk_x,
    output logic [9:0] spr_horz,
    output logic [9:0] spr_vert,
    output logic [1:0] spr_sel,
    output logic       spr_frame,
    output logic       mirror,
    input  logic [2:0] pix_in,
`ifdef DK_HIT_FLASH_EN
    input  logic       hit,
`endif
    output logic [2:0] draw_dk
);

    localparam int unsigned AW = $clog2(ANIM_DIV + 1);
    localparam int unsigned TW = $clog2(THROW_FRAMES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WALK_R = 2'd1;
    localparam logic [1:0] S_WALK_L = 2'd2;
    localparam logic [1:0] S_THROW  = 2'd3;

    logic [1:0]    state, state_d;
    logic          last_right, last_right_d;
    logic [9:0]    dk_x_d;
    logic [AW-1:0] anim_cnt, anim_cnt_d;
    logic          frame_d;
    logic [TW-1:0] throw_cnt, throw_cnt_d;
    logic          ack_d;
    logic          walk_step;
    logic          right_hit, left_hit;

    // Boundary tests in 11 bits so dk_x + STEP cannot wrap.
    assign right_hit = ({1'b0, dk_x} + 11'(STEP)) >= 11'(X_MAX);
    assign left_hit  = {1'b0, dk_x} <= 11'(X_MIN + STEP);

    always_comb begin
        state_d      = state;
        last_right_d = last_right;
        dk_x_d       = dk_x;
        anim_cnt_d   = anim_cnt;
        frame_d      = spr_frame;
        throw_cnt_d  = throw_cnt;
        ack_d        = 1'b0;
        walk_step    = 1'b0;

        if (frame_tick) begin
            case (state)
                S_THROW: begin
                    // Requests are ignored while throwing; dk_x is held on exit.
                    if (throw_cnt == TW'(THROW_FRAMES - 1)) begin
                        throw_cnt_d = '0;
                        if (enable) state_d = last_right ? S_WALK_R : S_WALK_L;
                        else        state_d = S_IDLE;
                    end else begin
                        throw_cnt_d = throw_cnt + 1'b1;
                    end
                end
                default: begin
                    if (throw_req) begin
                        // Throw beats the move and the boundary turn.
                        state_d     = S_THROW;
                        throw_cnt_d = '0;
                        ack_d       = 1'b1;
                        anim_cnt_d  = '0;
                        frame_d     = 1'b0;
                    end else if (!enable) begin
                        state_d    = S_IDLE;
                        anim_cnt_d = '0;
                        frame_d    = 1'b0;
                    end else begin
                        // Leaving IDLE moves on the same tick, in last_dir.
                        walk_step = 1'b1;
                    end
                end
            endcase
        end

        if (walk_step) begin
            if (anim_cnt == AW'(ANIM_DIV - 1)) begin
                anim_cnt_d = '0;
                frame_d    = ~spr_frame;
            end else begin
                anim_cnt_d = anim_cnt + 1'b1;
            end

            if (last_right) begin
                if (right_hit) begin
                    dk_x_d       = 10'(X_MAX);
                    state_d      = S_WALK_L;
                    last_right_d = 1'b0;
                end else begin
                    dk_x_d  = dk_x + 10'(STEP);
                    state_d = S_WALK_R;
                end
            end else begin
                if (left_hit) begin
                    dk_x_d       = 10'(X_MIN);
                    state_d      = S_WALK_R;
                    last_right_d = 1'b1;
                end else begin
                    dk_x_d  = dk_x - 10'(STEP);
                    state_d = S_WALK_L;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_right <= 1'b1;
            dk_x       <= 10'(X_MIN);
            anim_cnt   <= '0;
            spr_frame  <= 1'b0;
            throw_cnt  <= '0;
            throw_ack  <= 1'b0;
        end else begin
            state      <= state_d;
            last_right <= last_right_d;
            dk_x       <= dk_x_d;
            anim_cnt   <= anim_cnt_d;
            spr_frame  <= frame_d;
            throw_cnt  <= throw_cnt_d;
            throw_ack  <= ack_d;
        end
    end

    // Bank and flip follow the state, which only moves on frame_tick.
    // Side art faces left, so walking right needs the flip.
    always_comb begin
        spr_sel = 2'd0;
        mirror  = 1'b0;
        case (state)
            S_WALK_R: begin spr_sel = 2'd1; mirror = 1'b1;       end
            S_WALK_L: begin spr_sel = 2'd1; mirror = 1'b0;       end
            S_THROW:  begin spr_sel = 2'd2; mirror = last_right; end
            default:  begin spr_sel = 2'd0; mirror = 1'b0;       end
        endcase
    end

    // Pixel pipeline, stage 1: bounding box and sprite-local address.
    logic       in_box, in_box_q;
    logic [9:0] rel, h_loc, v_loc;

    assign in_box = ({1'b0, horz} >= {1'b0, dk_x}) &&
                    ({1'b0, horz} <  ({1'b0, dk_x} + 11'(SPR_W))) &&
                    ({1'b0, vert} >= 11'(DK_Y)) &&
                    ({1'b0, vert} <  11'(DK_Y + SPR_H));
    assign rel    = horz - dk_x;
    assign h_loc  = mirror ? (10'(SPR_W - 1) - rel) : rel;
    assign v_loc  = vert - 10'(DK_Y);

    // Stage 2 qualifiers. An unknown pix_in makes pix_known non-true in
    // four-state simulation, which selects the transparent branch.
    logic pix_known;
    logic blank;
    assign pix_known = (^pix_in == 1'b0) || (^pix_in == 1'b1);

`ifdef DK_HIT_FLASH_EN
    logic [5:0] flash_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_cnt <= 6'd0;
        end else if (hit) begin
            flash_cnt <= 6'd32;
        end else if (frame_tick && (flash_cnt != 6'd0)) begin
            flash_cnt <= flash_cnt - 6'd1;
        end
    end

    // Blink: blank during the half of each 8-frame window where bit 2 is set.
    assign blank = (flash_cnt != 6'd0) && flash_cnt[2];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_box_q <= 1'b0;
            spr_horz <= 10'd0;
            spr_vert <= 10'd0;
            draw_dk  <= 3'd0;
        end else begin
            in_box_q <= in_box;
            spr_horz <= in_box ? h_loc : 10'd0;
            spr_vert <= in_box ? v_loc : 10'd0;
            if (in_box_q && pix_known && !blank) draw_dk <= pix_in;
            else                                 draw_dk <= 3'd0;
        end
    end

endmodule

// File: tb/tb_dk_sprite_ctrl.sv
// Self-checking bench for dk_sprite_ctrl (default build, no hit flash).
// Reference model tracks position, heading, walking/throwing and animation
// as plain integers; pixel expectations come from box arithmetic.

module tb_dk_sprite_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, enable, throw_req, throw_ack;
    logic [9:0] horz, vert, dk_x, spr_horz, spr_vert;
    logic [1:0] spr_sel;
    logic       spr_frame, mirror;
    logic [2:0] pix_in, draw_dk;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dk_sprite_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .enable     (enable),
        .throw_req  (throw_req),
        .throw_ack  (throw_ack),
        .horz       (horz),
        .vert       (vert),
        .dk_x       (dk_x),
        .spr_horz   (spr_horz),
        .spr_vert   (spr_vert),
        .spr_sel    (spr_sel),
        .spr_frame  (spr_frame),
        .mirror     (mirror),
        .pix_in     (pix_in),
        .draw_dk    (draw_dk)
    );

    // Sprite memory stand-in: fixed pattern of the local address.
    function automatic logic [2:0] mem_pix(input logic [9:0] h, input logic [9:0] v);
        logic [2:0] lo;
        lo = {v[1:0], 1'b1};
        return h[2:0] ^ lo;
    endfunction

    assign pix_in = mem_pix(spr_horz, spr_vert);

    // Reference model.
    int m_x, m_dir, m_walk, m_throw_left, m_anim;
    bit m_frame;

    task automatic model_reset();
        m_x = 0; m_dir = 1; m_walk = 0; m_throw_left = 0; m_anim = 0; m_frame = 0;
    endtask

    function automatic logic [1:0] exp_sel();
        return (m_throw_left > 0) ? 2'd2 : (m_walk != 0) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic exp_mirror();
        return ((m_throw_left > 0) || (m_walk != 0)) && (m_dir > 0);
    endfunction

    task automatic model_tick(input bit en, input bit req, output bit acc);
        acc = 0;
        if (m_throw_left > 0) begin
            m_throw_left--;
            if (m_throw_left == 0) m_walk = en;
        end else if (req) begin
            m_throw_left = 16; m_walk = 0; m_anim = 0; m_frame = 0; acc = 1;
        end else if (!en) begin
            m_walk = 0; m_anim = 0; m_frame = 0;
        end else begin
            m_walk = 1;
            m_anim++;
            if (m_anim == 8) begin m_anim = 0; m_frame = ~m_frame; end
            m_x += 2 * m_dir;
            if (m_x >= 576) begin m_x = 576; m_dir = -1; end
            else if (m_x <= 0) begin m_x = 0; m_dir = 1; end
        end
    endtask

    bit         pipe_valid = 0;
    logic [2:0] pipe_exp;

    // One frame tick: pulse, sample ack at the tick edge and one cycle later.
    task automatic tick(input bit en, input bit req, output bit acc,
                        output logic ack0, output logic ack1);
        @(negedge clk);
        enable = en; throw_req = req; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        ack0 = throw_ack;
        model_tick(en, req, acc);
        @(posedge clk); #1;
        ack1 = throw_ack;
        pipe_valid = 0;
    endtask

    // Present one pixel; return stage-1 result for it and draw_dk of the
    // pixel presented in the previous cycle.
    task automatic px(input int h, input int v,
                      output logic [9:0] oh, output logic [9:0] ov,
                      output logic [9:0] eh, output logic [9:0] ev,
                      output logic [2:0] od, output logic [2:0] ed, output bit dv);
        bit inb;
        int rel;
        inb = (h >= m_x) && (h < m_x + 64) && (v >= 40) && (v < 72);
        rel = h - m_x;
        eh  = inb ? 10'(exp_mirror() ? 63 - rel : rel) : 10'd0;
        ev  = inb ? 10'(v - 40) : 10'd0;
        @(negedge clk);
        horz = 10'(h); vert = 10'(v);
        @(posedge clk); #1;
        oh = spr_horz; ov = spr_vert; od = draw_dk;
        dv = pipe_valid; ed = pipe_exp;
        pipe_exp   = inb ? mem_pix(eh, ev) : 3'd0;
        pipe_valid = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_tick = 0; enable = 0; throw_req = 0; horz = 0; vert = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dk_x !== 10'd0) begin errors++; $display("FAIL reset_dk_x got %0d want 0", dk_x); end
        checks++; if (spr_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", spr_sel); end
        checks++; if ({mirror, spr_frame, throw_ack} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {mirror, spr_frame, throw_ack}); end
        checks++; if ({spr_horz, spr_vert, draw_dk} !== 23'd0) begin errors++; $display("FAIL reset_pix got %0d/%0d/%0d want 0", spr_horz, spr_vert, draw_dk); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_walk();
        bit acc; logic a0, a1;
        for (int i = 1; i <= 9; i++) begin
            tick(1, 0, acc, a0, a1);
            if (i <= 3) begin
                checks++; if (dk_x !== 10'(2 * i)) begin errors++; $display("FAIL walk_x tick %0d got %0d want %0d", i, dk_x, 2 * i); end
                checks++; if ({spr_sel, mirror} !== 3'b011) begin errors++; $display("FAIL walk_sel tick %0d got %b want 011", i, {spr_sel, mirror}); end
            end
            checks++; if (spr_frame !== (i >= 8)) begin errors++; $display("FAIL walk_frame tick %0d got %b want %b", i, spr_frame, i >= 8); end
        end
        for (int n = 0; n < 400 && m_x != 574; n++) begin
            tick(1, 0, acc, a0, a1);
            checks++; if (dk_x !== 10'(m_x) || spr_frame !== m_frame) begin errors++; $display("FAIL walk_run got x=%0d f=%b want x=%0d f=%b", dk_x, spr_frame, m_x, m_frame); end
        end
        tick(1, 0, acc, a0, a1);
        checks++; if (dk_x !== 10'd576) begin errors++; $display("FAIL edge_x got %0d want 576", dk_x); end
        checks++; if ({spr_sel, mirror} !== 3'b010) begin errors++; $display("FAIL edge_turn got %b want 010", {spr_sel, mirror}); end
        tick(1, 0, acc, a0, a1);
        checks++; if (dk_x !== 10'd574) begin errors++; $display("FAIL edge_back got %0d want 574", dk_x); end
    endtask

    task automatic test_pixels(input bit want_right);
        bit acc, dv; logic a0, a1;
        logic [9:0] oh, ov, eh, ev; logic [2:0] od, ed;
        int hs[8] = '{100, 163, 164, 99, 130, 130, 130, 0};
        int vs[8] = '{40, 40, 40, 40, 71, 72, 39, 0};
        for (int n = 0; n < 1000 && !(m_x == 100 && (m_dir > 0) == want_right); n++)
            tick(1, 0, acc, a0, a1);
        checks++; if (dk_x !== 10'd100 || mirror !== want_right) begin errors++; $display("FAIL px_setup got x=%0d m=%b want x=100 m=%b", dk_x, mirror, want_right); end
        for (int i = 0; i < 8; i++) begin
            px(hs[i], vs[i], oh, ov, eh, ev, od, ed, dv);
            checks++; if (oh !== eh || ov !== ev) begin errors++; $display("FAIL px_addr h=%0d v=%0d got %0d/%0d want %0d/%0d", hs[i], vs[i], oh, ov, eh, ev); end
            if (dv) begin
                checks++; if (od !== ed) begin errors++; $display("FAIL px_draw after h=%0d got %0d want %0d", hs[i-1], od, ed); end
            end
        end
    endtask

    task automatic test_throw();
        bit acc; logic a0, a1;
        tick(1, 1, acc, a0, a1);
        checks++; if (a0 !== 1'b1 || a1 !== 1'b0) begin errors++; $display("FAIL throw_ack got %b%b want 10", a0, a1); end
        checks++; if (spr_sel !== 2'd2 || dk_x !== 10'd100 || mirror !== 1'b1) begin errors++; $display("FAIL throw_enter got sel=%0d x=%0d m=%b want 2/100/1", spr_sel, dk_x, mirror); end
        for (int i = 1; i <= 15; i++) begin
            tick(1, i == 5, acc, a0, a1);
            checks++; if (a0 !== 1'b0 || spr_sel !== 2'd2 || dk_x !== 10'd100) begin errors++; $display("FAIL throw_hold tick %0d got ack=%b sel=%0d x=%0d", i, a0, spr_sel, dk_x); end
        end
        tick(1, 0, acc, a0, a1);
        checks++; if (spr_sel !== 2'd1 || dk_x !== 10'd100) begin errors++; $display("FAIL throw_exit got sel=%0d x=%0d want 1/100", spr_sel, dk_x); end
        tick(1, 0, acc, a0, a1);
        checks++; if (dk_x !== 10'(m_x)) begin errors++; $display("FAIL throw_resume got %0d want %0d", dk_x, m_x); end
    endtask

    task automatic test_reset_mid_throw();
        bit acc; logic a0, a1;
        horz = 10'd130; vert = 10'd50;
        tick(1, 1, acc, a0, a1);
        for (int i = 0; i < 3; i++) tick(1, 0, acc, a0, a1);
        @(negedge clk); #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (dk_x !== 10'd0 || spr_sel !== 2'd0 || mirror !== 1'b0) begin errors++; $display("FAIL async_rst got x=%0d sel=%0d m=%b want 0", dk_x, spr_sel, mirror); end
        checks++; if ({spr_horz, spr_vert, draw_dk, throw_ack, spr_frame} !== 25'd0) begin errors++; $display("FAIL async_rst_pix got %0d/%0d/%0d want 0", spr_horz, spr_vert, draw_dk); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, acc, a0, a1);
            checks++; if (a0 !== 1'b0 || a1 !== 1'b0 || spr_sel !== 2'd0) begin errors++; $display("FAIL post_rst got ack=%b%b sel=%0d want 00/0", a0, a1, spr_sel); end
        end
    endtask

    task automatic test_random();
        bit acc, dv, en, req; logic a0, a1;
        logic [9:0] oh, ov, eh, ev; logic [2:0] od, ed;
        int h, v;
        for (int t = 0; t < 300; t++) begin
            en  = ($urandom_range(0, 3) != 0);
            req = ($urandom_range(0, 9) == 0);
            tick(en, req, acc, a0, a1);
            checks++; if (a0 !== acc || a1 !== 1'b0) begin errors++; $display("FAIL rnd_ack t=%0d got %b%b want %b0", t, a0, a1, acc); end
            checks++; if (dk_x !== 10'(m_x) || spr_sel !== exp_sel() || mirror !== exp_mirror() || spr_frame !== m_frame) begin
                errors++;
                $display("FAIL rnd_state t=%0d got x=%0d sel=%0d m=%b f=%b want x=%0d sel=%0d m=%b f=%b",
                         t, dk_x, spr_sel, mirror, spr_frame, m_x, exp_sel(), exp_mirror(), m_frame);
            end
            for (int k = 0; k < 4; k++) begin
                h = (k == 3) ? 0 : m_x + int'($urandom_range(0, 80)) - 8;
                if (h < 0) h = 0;
                v = (k == 3) ? 0 : int'($urandom_range(30, 80));
                px(h, v, oh, ov, eh, ev, od, ed, dv);
                checks++; if (oh !== eh || ov !== ev) begin errors++; $display("FAIL rnd_addr h=%0d v=%0d got %0d/%0d want %0d/%0d", h, v, oh, ov, eh, ev); end
                if (dv) begin
                    checks++; if (od !== ed) begin errors++; $display("FAIL rnd_draw t=%0d got %0d want %0d", t, od, ed); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_pixels(1'b0);
        test_pixels(1'b1);
        test_throw();
        test_reset_mid_throw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
